// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types: per-latch control state and hazard controller FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DRAIN = 2'd1,
    CTRL_HALT  = 2'd2
  } hzctrl_state_t;

  // Load in EX feeding a DEC source; $0 is hardwired and never a real dependency.
  function automatic logic load_use(input logic       dren_ex,
                                    input logic [4:0] rt_ex,
                                    input logic [4:0] rs_dec,
                                    input logic [4:0] rt_dec);
    return dren_ex && (rt_ex != 5'd0) && ((rt_ex == rs_dec) || (rt_ex == rt_dec));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; slave is the controller side.
interface pipeline_hazard_ctrl_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             dREN_mem;
  logic             dWEN_mem;
  logic             dREN_ex;
  logic [4:0]       rt_ex;
  logic [4:0]       rs_dec;
  logic [4:0]       rt_dec;
  logic             flush_ex;
  logic             halt_dec;
  logic             halt_wb;
  logic             pc_en;
  pipe_state_t      fd_state;
  pipe_state_t      de_state;
  pipe_state_t      em_state;
  pipe_state_t      mw_state;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, rt_ex, rs_dec, rt_dec,
           flush_ex, halt_dec, halt_wb,
    input  pc_en, fd_state, de_state, em_state, mw_state, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, rt_ex, rs_dec, rt_dec,
           flush_ex, halt_dec, halt_wb,
    output pc_en, fd_state, de_state, em_state, mw_state, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-latch enable/stall/nop, PC enable, halt drain, perf counters.
//  state      | meaning
//  CTRL_RUN   | normal issue
//  CTRL_DRAIN | halt accepted in DEC, no further fetch, waiting for it to reach WB
//  CTRL_HALT  | halt retired, pipeline frozen until reset
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  pipeline_hazard_ctrl_if.slave  bus
);

  hzctrl_state_t    state, state_next;
  logic             halted;
  logic             dwait;
  logic             lduse;
  logic             flush_take;
  logic             stall_inc;
  logic             pc_en;
  pipe_state_t      fd, de, em, mw;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign dwait = (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit;
  assign lduse = load_use(bus.dREN_ex, bus.rt_ex, bus.rs_dec, bus.rt_dec);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= CTRL_RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      if (state_next == CTRL_HALT) halted <= 1'b1;
    end
  end

  always_comb begin
    pc_en      = 1'b1;
    fd         = PIPE_ENABLE;
    de         = PIPE_ENABLE;
    em         = PIPE_ENABLE;
    mw         = PIPE_ENABLE;
    flush_take = 1'b0;
    state_next = state;

    if (!nRST) begin
      pc_en = 1'b0;
      fd    = PIPE_NOP;
      de    = PIPE_NOP;
      em    = PIPE_NOP;
      mw    = PIPE_NOP;
    end else if (state == CTRL_HALT) begin
      pc_en = 1'b0;
      fd    = PIPE_STALL;
      de    = PIPE_STALL;
      em    = PIPE_STALL;
      mw    = PIPE_STALL;
    end else if (dwait) begin
      // MEM/WB gets a bubble so the stalled access does not write back twice.
      pc_en = 1'b0;
      fd    = PIPE_STALL;
      de    = PIPE_STALL;
      em    = PIPE_STALL;
      mw    = PIPE_NOP;
    end else if (bus.flush_ex) begin
      flush_take = 1'b1;
      fd         = PIPE_NOP;
      de         = PIPE_NOP;
    end else if (lduse) begin
      pc_en = 1'b0;
      fd    = PIPE_STALL;
      de    = PIPE_NOP;
    end else if (!bus.ihit) begin
      pc_en = 1'b0;
      fd    = PIPE_NOP;
    end else if (state == CTRL_DRAIN) begin
      pc_en = 1'b0;
      fd    = PIPE_NOP;
    end

    case (state)
      CTRL_RUN:   if (bus.halt_dec && (de == PIPE_ENABLE)) state_next = CTRL_DRAIN;
      CTRL_DRAIN: if (bus.flush_ex)     state_next = CTRL_RUN;
                  else if (bus.halt_wb) state_next = CTRL_HALT;
      CTRL_HALT:  state_next = CTRL_HALT;
      default:    state_next = CTRL_RUN;
    endcase
  end

  assign stall_inc = !pc_en && (state != CTRL_HALT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_take),
    .count (flush_cnt)
  );

  assign bus.pc_en     = pc_en;
  assign bus.fd_state  = fd;
  assign bus.de_state  = de;
  assign bus.em_state  = em;
  assign bus.mw_state  = mw;
  assign bus.halted    = halted;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
  localparam int EN    = 0;
  localparam int ST    = 1;
  localparam int NP    = 2;

  logic CLK;
  logic nRST;
  int   n_assert = 0;
  int   n_fail   = 0;

  // model: mode 0 running, 1 draining, 2 halted
  int m_mode;
  bit m_halted;
  int m_sc;
  int m_fc;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dREN_mem = 1'b0; bus.dWEN_mem = 1'b0;
    bus.dREN_ex = 1'b0; bus.rt_ex = 5'd0; bus.rs_dec = 5'd0; bus.rt_dec = 5'd0;
    bus.flush_ex = 1'b0; bus.halt_dec = 1'b0; bus.halt_wb = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick(input string tag);
    int  pc, s[4];
    bit  flushed, dw, ld;
    #1;
    if (!nRST) begin
      m_mode = 0; m_halted = 0; m_sc = 0; m_fc = 0;
    end
    dw = (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit;
    ld = bus.dREN_ex && bus.rt_ex != 0 && (bus.rt_ex == bus.rs_dec || bus.rt_ex == bus.rt_dec);
    pc = 1; s = '{EN, EN, EN, EN}; flushed = 0;
    if (!nRST)             begin pc = 0; s = '{NP, NP, NP, NP}; end
    else if (m_mode == 2)  begin pc = 0; s = '{ST, ST, ST, ST}; end
    else if (dw)           begin pc = 0; s = '{ST, ST, ST, NP}; end
    else if (bus.flush_ex) begin s[0] = NP; s[1] = NP; flushed = 1; end
    else if (ld)           begin pc = 0; s[0] = ST; s[1] = NP; end
    else if (!bus.ihit)    begin pc = 0; s[0] = NP; end
    else if (m_mode == 1)  begin pc = 0; s[0] = NP; end

    chk({tag, ".pc_en"},     32'(bus.pc_en),     32'(pc));
    chk({tag, ".fd"},        32'(bus.fd_state),  32'(s[0]));
    chk({tag, ".de"},        32'(bus.de_state),  32'(s[1]));
    chk({tag, ".em"},        32'(bus.em_state),  32'(s[2]));
    chk({tag, ".mw"},        32'(bus.mw_state),  32'(s[3]));
    chk({tag, ".halted"},    32'(bus.halted),    32'(m_halted));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_sc));
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(m_fc));

    @(posedge CLK);
    if (nRST) begin
      if (pc == 0 && m_mode != 2) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
      if (flushed)                m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
      if (m_mode == 0 && bus.halt_dec && s[1] == EN) m_mode = 1;
      else if (m_mode == 1 && bus.flush_ex)          m_mode = 0;
      else if (m_mode == 1 && bus.halt_wb)           m_mode = 2;
      if (m_mode == 2) m_halted = 1;
    end
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    m_mode = 0; m_halted = 0; m_sc = 0; m_fc = 0;
    @(negedge CLK);
    tick("reset0");
    tick("reset1");
    nRST = 1'b1;

    // idle running
    for (int i = 0; i < 10; i++) tick("idle");
    chk("idle.stall_zero", 32'(bus.stall_cnt), 32'd0);

    // load-use on rs, then on rt, then $0 which must not stall
    bus.dREN_ex = 1; bus.rt_ex = 5; bus.rs_dec = 5; bus.rt_dec = 7;
    tick("lduse_rs");
    chk("lduse.stall_one", 32'(bus.stall_cnt), 32'd1);
    bus.rs_dec = 2; bus.rt_dec = 5;
    tick("lduse_rt");
    bus.rt_ex = 0; bus.rs_dec = 0; bus.rt_dec = 0;
    tick("lduse_r0");
    idle_inputs();
    tick("post_lduse");

    // store wait 3 cycles then hit
    bus.dWEN_mem = 1; bus.dhit = 0;
    for (int i = 0; i < 3; i++) tick("dwait");
    bus.dhit = 1;
    tick("dwait_hit");
    idle_inputs();
    tick("post_dwait");

    // flush held under dwait, taken on dhit cycle
    bus.dREN_mem = 1; bus.dhit = 0; bus.flush_ex = 1;
    for (int i = 0; i < 2; i++) tick("flush_dwait");
    chk("flush_dwait.fc_zero", 32'(bus.flush_cnt), 32'd0);
    bus.dhit = 1;
    tick("flush_hit");
    idle_inputs();
    tick("post_flush");
    chk("flush.fc_one", 32'(bus.flush_cnt), 32'd1);

    // flush beats load-use
    bus.flush_ex = 1; bus.dREN_ex = 1; bus.rt_ex = 3; bus.rs_dec = 3;
    tick("flush_vs_lduse");
    idle_inputs();

    // halt killed by a flush
    bus.halt_dec = 1;
    tick("halt_accept");
    bus.halt_dec = 0;
    tick("drain");
    bus.flush_ex = 1;
    tick("drain_flush");
    bus.flush_ex = 0;
    tick("back_run");
    chk("kill.halted_zero", 32'(bus.halted), 32'd0);

    // halt retired
    bus.halt_dec = 1;
    tick("halt_accept2");
    bus.halt_dec = 0;
    bus.ihit = 0;
    tick("drain_nohit");
    bus.ihit = 1;
    tick("drain2");
    bus.halt_wb = 1;
    tick("halt_wb");
    bus.halt_wb = 0;
    chk("halt.halted_one", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 3; i++) tick("halted");

    // reset during drain with a data wait pending
    nRST = 0; tick("rst_leave_halt"); nRST = 1;
    bus.halt_dec = 1;
    tick("halt_accept3");
    bus.halt_dec = 0; bus.dREN_mem = 1; bus.dhit = 0;
    tick("drain_dwait");
    nRST = 0;
    #1;
    chk("async_rst.pc_en", 32'(bus.pc_en), 32'd0);
    chk("async_rst.fd", 32'(bus.fd_state), 32'(NP));
    chk("async_rst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    tick("in_reset");
    nRST = 1;
    idle_inputs();
    tick("after_reset");

    // randomized traffic, including counter saturation and occasional resets
    for (int i = 0; i < 400; i++) begin
      nRST         = ($urandom_range(0, 99) >= 2);
      bus.ihit     = ($urandom_range(0, 9) != 0);
      bus.dhit     = $urandom_range(0, 1) == 1;
      bus.dREN_mem = ($urandom_range(0, 4) == 0);
      bus.dWEN_mem = ($urandom_range(0, 5) == 0);
      bus.dREN_ex  = ($urandom_range(0, 2) == 0);
      bus.rt_ex    = 5'($urandom_range(0, 3));
      bus.rs_dec   = 5'($urandom_range(0, 3));
      bus.rt_dec   = 5'($urandom_range(0, 3));
      bus.flush_ex = ($urandom_range(0, 5) == 0);
      bus.halt_dec = ($urandom_range(0, 9) == 0);
      bus.halt_wb  = ($urandom_range(0, 19) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
